// File: rtl/hs_rx_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : hs_rx_pkg                                                       |
// | Brief    : Shared state type and sizing helper for the hs_rx_sink receiver |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

package hs_rx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        WAIT_LO = 2'd2
    } hs_rx_state_t;

    // Occupancy needs one bit more than the pointers so a full FIFO is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hs_rx_fifo.sv
// +----------------------------------------------------------------------------+
// | Module   : hs_rx_fifo                                                      |
// | Brief    : DEPTH x DATA_WIDTH first-word fall-through FIFO with occupancy  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module hs_rx_fifo
    import hs_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 3,
    parameter int DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push_i,
    input  logic [DATA_WIDTH-1:0]         push_data_i,
    input  logic                          pop_i,
    output logic [DATA_WIDTH-1:0]         head_o,
    output logic                          valid_o,
    output logic [cnt_width(DEPTH)-1:0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic                  do_push;
    logic                  do_pop;

    assign do_push = push_i && (count_q != CNT_W'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Storage is cleared on reset so the head reads zero until the first push.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/hs_rx_sink.sv
// +----------------------------------------------------------------------------+
// | Module   : hs_rx_sink                                                      |
// | Brief    : 4-phase req/ack bundled-data receiver feeding a valid/ready FIFO|
// |            Optional HS_RX_TIMEOUT_EN adds a sticky WAIT_LO timeout flag.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module hs_rx_sink
    import hs_rx_pkg::*;
#(
    parameter int DATA_WIDTH     = 3,
    parameter int DEPTH          = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_in,
    input  logic [DATA_WIDTH-1:0]         data_in,
    output logic                          ack_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [cnt_width(DEPTH)-1:0]   fifo_count,
    output logic                          err_timeout
);

    localparam int CNT_W = cnt_width(DEPTH);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    hs_rx_state_t           state_q;
    logic                   ack_q;
    logic                   fifo_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_in};
        end
    end

    assign req_s     = sync_q[SYNC_STAGES-1];
    assign fifo_full = (fifo_count == CNT_W'(DEPTH));

    // Ack is withheld while full; that stall is the only backpressure upstream sees.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_s && !fifo_full) begin
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    state_q <= WAIT_LO;
                    ack_q   <= 1'b1;
                end
                WAIT_LO: begin
                    if (!req_s) begin
                        state_q <= IDLE;
                        ack_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    assign ack_out = ack_q;

    hs_rx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (state_q == CAPTURE),
        .push_data_i (data_in),
        .pop_i       (out_ready),
        .head_o      (out_data),
        .valid_o     (out_valid),
        .count_o     (fifo_count)
    );

`ifdef HS_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q;
    logic            err_q;

    // Counter saturates at the limit so the flag cannot be missed by wrap-around.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state_q == WAIT_LO) begin
                if (to_cnt_q != TO_W'(TIMEOUT_CYCLES)) begin
                    to_cnt_q <= to_cnt_q + 1'b1;
                end
            end else begin
                to_cnt_q <= '0;
            end
            if (to_cnt_q == TO_W'(TIMEOUT_CYCLES)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

endmodule

`default_nettype wire
